smol_alu_mc: RTL and testbench
==============================

// Module: smol_alu_mc
// PURPOSE
// - Multi-cycle, parametrised-width integer ALU for smolCore execute stage.
// - Single-cycle logic/arith/shift/compare ops plus iterative MUL (and optional DIV/REM).
// - valid/ready in/out handshakes; registered result with carry/overflow/zero flags.
// - Sits between the operand-select mux and writeback.
// PARAMETERS
// - WIDTH   32  operand/result width (>=8, power of 2)
// - SHAMT_W $clog2(WIDTH)  shift-amount bits taken from b[SHAMT_W-1:0]
// PORTS
// - clk        in   1      sole clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      operands/op valid
// - in_ready   out  1      unit can accept
// - op_sel     in   5      smol_alu_pkg::alu_op_e
// - a          in   WIDTH  rs1
// - b          in   WIDTH  rs2 or immediate
// - out_valid  out  1      result valid
// - out_ready  in   1      consumer accepts result
// - alu_out    out  WIDTH  result
// - carry      out  1      ADD carry-out / SUB no-borrow
// - overflow   out  1      signed overflow (ADD/SUB only)
// - zero       out  1      alu_out == 0
// BEHAVIOUR
// - Reset: state IDLE, out_valid=0, alu_out=0, carry=0, overflow=0, zero=1. Takes effect even mid-MUL/DIV; in-flight op discarded.
// - FSM: IDLE -> (accept single-cycle op) DONE; IDLE -> (accept MUL/DIV/REM) BUSY; BUSY -(count==WIDTH-1)-> DONE; DONE -(out_ready)-> IDLE.
// - Back-to-back: in DONE with out_ready, a new op is accepted the same cycle.
// - in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready; operands and op are latched at accept.
// - Latency accept->out_valid:
//   - single-cycle ops: 1 cycle
//   - MUL/DIV/REM: WIDTH+1 cycles
// - out_valid=1 exactly in DONE. Outputs hold stable until out_ready.
// - Ops:
//   - ADD, SUB, AND, OR (bitwise), XOR
//   - SLL, SRL, SRA (shift by b[SHAMT_W-1:0])
//   - SLT (signed), SLTU: result {WIDTH-1 zeros, cmp}
//   - MUL: low WIDTH bits of a*b, shift-add, one bit per cycle
// - Flags:
//   - ADD: carry = bit WIDTH of {0,a}+{0,b}.
//   - SUB: carry = bit WIDTH of {0,a}+{0,~b}+1, so a=b gives 1.
//   - overflow: ADD when a and b have the same sign and the sign differs from the result; SUB when a and b differ in sign and the sign differs from a.
//   - All other ops: carry=overflow=0.
//   - zero is valid for every op.
// - Undefined op_sel codes: result 0, carry=overflow=0, zero=1, 1-cycle latency.
// - No combinational path from in_* to out_*; in_ready depends only on state and out_ready.
// CONFIGURATION
// - SMOL_ALU_DIV_EN defined:
//   - adds DIV, DIVU, REM, REMU via restoring division, one quotient bit per cycle, WIDTH+1 latency.
//   - Divide by zero: quotient all-ones, remainder = a.
//   - Signed MIN/-1: quotient = a, remainder 0.
//   - Signs are fixed up in the DONE-entry cycle.
// - SMOL_ALU_DIV_EN undefined: DIV* / REM* codes are treated as undefined ops (result 0, 1 cycle).
// STRUCTURE
// - smol_alu_pkg:
//   - alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SRL=5, SLL=6, SLTU=7, SRA=8, SLT=9, MUL=10, DIV=11, DIVU=12, REM=13, REMU=14
//   - state_e: IDLE, BUSY, DONE
//   - function is_multicycle(alu_op_e)
// - Sub-module smol_alu_iter: shared shift/add-subtract datapath for MUL and DIV.
//   - Ports: clk, rst, start, op, a, b, busy, done, result.
//   - Iteration counter width $clog2(WIDTH).
// - Top holds the FSM, single-cycle combinational unit, result/flag registers and handshake.
// TESTING (WIDTH=32)
// - ADD 0xFFFFFFFF+0x1 -> alu_out=0, carry=1, overflow=0, zero=1, out_valid 1 cycle after accept.
// - SUB 0x80000000-0x1 -> 0x7FFFFFFF, overflow=1, carry=1; SUB 5-5 -> 0, carry=1, zero=1.
// - SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
// - MUL 0x12345678*0x10 -> 0x23456780; out_valid at cycle 33, in_ready=0 during BUSY.
// - Hold out_ready=0 3 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> next op accepted same cycle.
// - rst pulse at BUSY cycle 10 of MUL -> next cycle out_valid=0, in_ready=1, zero=1.
// - SMOL_ALU_DIV_EN: DIV -7/2 -> -3, REM -> -1; DIVU 7/0 -> 0xFFFFFFFF, REMU -> 7; DIV 0x80000000/-1 -> 0x80000000.

Source files
------------

// File: rtl/smol_alu_pkg.sv
// Shared types for the smolCore multi-cycle ALU: op codes, FSM states, op classification.
// SMOL_ALU_DIV_EN adds DIV/DIVU/REM/REMU to the multi-cycle op set.
package smol_alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SRL  = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_MUL  = 5'd10,
    ALU_DIV  = 5'd11,
    ALU_DIVU = 5'd12,
    ALU_REM  = 5'd13,
    ALU_REMU = 5'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(alu_op_e op);
`ifdef SMOL_ALU_DIV_EN
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
`else
    return (op == ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/smol_alu_iter.sv
// Iterative shift-add multiplier / restoring divider (divider only with SMOL_ALU_DIV_EN).
// Latency: one bit per cycle, done asserted on the WIDTH-th iteration with the final result.
// Backpressure: none; start is only issued while idle, owner holds result after done.
module smol_alu_iter
  import smol_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  // acc: product / partial remainder; sh: multiplier / dividend-then-quotient; opb: multiplicand / divisor
  logic [WIDTH-1:0] acc, sh, opb;
  logic [WIDTH-1:0] acc_nxt, sh_nxt, opb_nxt;
  logic [CW-1:0]    cnt;
  alu_op_e          op_r;

`ifdef SMOL_ALU_DIV_EN
  logic             neg_q, neg_r, div0, sgn_op;
  logic [WIDTH:0]   rs, rs_sub;
  assign sgn_op = (op == ALU_DIV) || (op == ALU_REM);
`endif

  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_comb begin
    acc_nxt = acc;
    sh_nxt  = sh;
    opb_nxt = opb;
`ifdef SMOL_ALU_DIV_EN
    rs      = {acc, sh[WIDTH-1]};
    rs_sub  = rs - {1'b0, opb};
`endif
    if (op_r == ALU_MUL) begin
      acc_nxt = sh[0] ? acc + opb : acc;
      opb_nxt = opb << 1;
      sh_nxt  = sh >> 1;
    end
`ifdef SMOL_ALU_DIV_EN
    else if (!rs_sub[WIDTH]) begin
      acc_nxt = rs_sub[WIDTH-1:0];
      sh_nxt  = {sh[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = rs[WIDTH-1:0];
      sh_nxt  = {sh[WIDTH-2:0], 1'b0};
    end
`endif
  end

  // Sign fix-up happens on the final iteration so the owner latches a finished value.
  always_comb begin
    result = acc_nxt;
`ifdef SMOL_ALU_DIV_EN
    case (op_r)
      ALU_DIV, ALU_DIVU: result = div0 ? '1 : (neg_q ? -sh_nxt : sh_nxt);
      ALU_REM, ALU_REMU: result = neg_r ? -acc_nxt : acc_nxt;
      default:           result = acc_nxt;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      sh   <= '0;
      opb  <= '0;
      op_r <= ALU_ADD;
`ifdef SMOL_ALU_DIV_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
      op_r <= op;
`ifdef SMOL_ALU_DIV_EN
      if (op == ALU_MUL) begin
        sh  <= b;
        opb <= a;
      end else begin
        sh  <= (sgn_op && a[WIDTH-1]) ? -a : a;
        opb <= (sgn_op && b[WIDTH-1]) ? -b : b;
      end
      neg_q <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn_op && a[WIDTH-1];
      div0  <= (b == '0);
`else
      sh  <= b;
      opb <= a;
`endif
    end else if (busy) begin
      acc  <= acc_nxt;
      sh   <= sh_nxt;
      opb  <= opb_nxt;
      cnt  <= cnt + CW'(1);
      busy <= !done;
    end
  end

endmodule

// File: rtl/smol_alu_mc.sv
// Execute-stage integer ALU: 1-cycle logic/arith/shift/compare, WIDTH+1-cycle MUL (and DIV/REM with SMOL_ALU_DIV_EN).
// Result and flags are registered; they hold in DONE until out_ready, and in_ready drops while busy or stalled.
module smol_alu_mc
  import smol_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  state_e           state, state_nxt;
  alu_op_e          op;
  logic             accept, op_mc, start_mc;
  logic             iter_busy, iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic [WIDTH:0]   sum, diff;
  logic [SHAMT_W-1:0] shamt;

  assign op       = alu_op_e'(op_sel);
  assign op_mc    = is_multicycle(op);
  assign accept   = in_valid && in_ready;
  assign start_mc = accept && op_mc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_mc ? BUSY : DONE;
      BUSY: if (iter_busy && iter_done) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? (op_mc ? BUSY : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  // Single-cycle unit; SUB carry is the no-borrow bit of a + ~b + 1.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      ALU_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  sc_res = a & b;
      ALU_OR:   sc_res = a | b;
      ALU_XOR:  sc_res = a ^ b;
      ALU_SRL:  sc_res = a >> shamt;
      ALU_SLL:  sc_res = a << shamt;
      ALU_SRA:  sc_res = $signed(a) >>> shamt;
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  sc_res = '0;
    endcase
  end

  smol_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_mc),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (iter_busy),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out  <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else if (accept && !op_mc) begin
      alu_out  <= sc_res;
      carry    <= sc_c;
      overflow <= sc_v;
      zero     <= (sc_res == '0);
    end else if ((state == BUSY) && iter_busy && iter_done) begin
      alu_out  <= iter_result;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= (iter_result == '0);
    end
  end

endmodule

// File: tb/tb_smol_alu_mc.sv
// Randomised scoreboard bench for smol_alu_mc (WIDTH=32); define SMOL_ALU_DIV_EN to cover DIV/REM.
module tb_smol_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   op_sel = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic         carry, overflow, zero;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  smol_alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sel    (op_sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model from the arithmetic definitions, using 64-bit integers.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, t;
    logic [32:0] s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e  = '0;
    case (op)
      5'd0: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[31:0];
        e.c = s[32];
        t = sx + sy;
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'd1: begin
        e.r = x - y;
        e.c = (x >= y);
        t = sx - sy;
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'd2:  e.r = x & y;
      5'd3:  e.r = x | y;
      5'd4:  e.r = x ^ y;
      5'd5:  e.r = x >> y[4:0];
      5'd6:  e.r = x << y[4:0];
      5'd7:  e.r = (x < y) ? 32'd1 : 32'd0;
      5'd8:  e.r = 32'(sx >>> y[4:0]);
      5'd9:  e.r = (sx < sy) ? 32'd1 : 32'd0;
      5'd10: e.r = 32'(longint'(x) * longint'(y));
`ifdef SMOL_ALU_DIV_EN
      5'd11: e.r = (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
      5'd12: e.r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd13: e.r = (y == 0) ? x : 32'(sx % sy);
      5'd14: e.r = (y == 0) ? x : x % y;
`endif
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic int lat_of(input logic [4:0] op);
`ifdef SMOL_ALU_DIV_EN
    return (op >= 5'd10 && op <= 5'd14) ? W + 1 : 1;
`else
    return (op == 5'd10) ? W + 1 : 1;
`endif
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 16));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares every presented output against the scoreboard head; pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got %h with empty scoreboard at %0t", alu_out, $time);
        end else begin
          e = exp_q[0];
          chk("alu_out", alu_out, e.r);
          chk("carry", {31'd0, carry}, {31'd0, e.c});
          chk("overflow", {31'd0, overflow}, {31'd0, e.v});
          chk("zero", {31'd0, zero}, {31'd0, e.z});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    op_sel   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1 within 500 cycles");
    end else begin
      exp_q.push_back(model(op, x, y));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string name, input int req_lat, input bit busy_chk);
    int n;
    bit bad;
    n = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && busy_chk && in_ready) bad = 1;
    end while (!out_valid && n < 200);
    chk(name, 32'(n), 32'(req_lat));
    if (busy_chk) chk("in_ready_busy", {31'd0, bad}, 32'd0);
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    issue(op, x, y);
    lat_check("latency", lat_of(op), lat_of(op) > 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic [4:0] rop;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    @(posedge clk);
    #1;

    run(5'd0, 32'hFFFF_FFFF, 32'h1);
    run(5'd1, 32'h8000_0000, 32'h1);
    run(5'd1, 32'd5, 32'd5);
    run(5'd8, 32'h8000_0000, 32'd31);
    run(5'd9, 32'hFFFF_FFFF, 32'd1);
    run(5'd7, 32'hFFFF_FFFF, 32'd1);
    run(5'd10, 32'h1234_5678, 32'h10);
    run(5'd20, 32'h1234_5678, 32'h10);
    run(5'd11, 32'hFFFF_FFF9, 32'd2);
    run(5'd13, 32'hFFFF_FFF9, 32'd2);
    run(5'd12, 32'd7, 32'd0);
    run(5'd14, 32'd7, 32'd0);
    run(5'd11, 32'h8000_0000, 32'hFFFF_FFFF);
    run(5'd13, 32'h8000_0000, 32'hFFFF_FFFF);

    // Stall in DONE, then release with a new op presented in the same cycle.
    out_ready = 1'b0;
    issue(5'd0, 32'd3, 32'd4);
    lat_check("hold_latency", 1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    op_sel = 5'd1;
    a = 32'd10;
    b = 32'd3;
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(model(5'd1, 32'd10, 32'd3));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Reset in BUSY cycle 10 of a MUL: the in-flight op must vanish.
    issue(5'd10, 32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_zero", {31'd0, zero}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    run(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    rand_rdy = 1;
    for (int i = 0; i < 200; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      issue(rop, rnd_val(), rnd_val());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    rand_rdy = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
